fwd_hazard_unit: RTL and testbench

Parametrised successor to the two-operand forwarding mux-select logic. The block owns the destination-tag pipeline (EX/MEM/WB) rather than taking the tags as inputs. It resolves forwarding for NSRC source operands at ID and registers the selects into EX. It also detects load-use hazards and generates a one-cycle stall/bubble, honours external freeze and flush, and keeps a saturating stall-cycle counter. It sits beside the ID/EX pipeline registers and drives the EX operand muxes.

---
 rtl/fwd_hazard_unit.sv | 137 +++++++++++++
 tb/tb_fwd_hazard_unit.sv | 238 +++++++++++++++++++++++
 2 files changed

// File: rtl/fwd_hazard_unit.sv
// rtl/fwd_hazard_unit.sv - operand forwarding select and load-use hazard unit
//
// Owns the EX/MEM/WB destination-tag pipeline. It resolves bypass selects for
// NSRC source operands at ID and registers them into EX. It also raises a
// one-cycle load-use stall and counts stall cycles (saturating).
//
// Ports:
//   clk, reset       rising-edge clock, synchronous active-high reset
//   stall_ext        freeze: every register holds
//   flush            kill the instruction in ID (it enters EX as a bubble)
//   id_valid         ID holds a real instruction
//   id_src           NSRC packed source register numbers, operand i = slice i
//   id_src_used      operand i is actually read
//   id_dst, id_wr    destination register and its write enable
//   id_load          the ID instruction is a load
//   stall            combinational load-use hazard: hold PC/IF/ID
//   fwd_sel          registered EX select per operand:
//                      00 = regfile, 10 = MEM result, 11 = WB result
//   wb_dst, wb_wr    register-file write port (WB stage tag)
//   stall_cnt        saturating count of load-use stall cycles

module fwd_hazard_unit #(
  parameter int AW    = 5,
  parameter int NSRC  = 2,
  parameter int CNT_W = 16
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                stall_ext,
  input  logic                flush,
  input  logic                id_valid,
  input  logic [NSRC*AW-1:0]  id_src,
  input  logic [NSRC-1:0]     id_src_used,
  input  logic [AW-1:0]       id_dst,
  input  logic                id_wr,
  input  logic                id_load,
  output logic                stall,
  output logic [2*NSRC-1:0]   fwd_sel,
  output logic [AW-1:0]       wb_dst,
  output logic                wb_wr,
  output logic [CNT_W-1:0]    stall_cnt
);

  localparam logic [1:0] SEL_RF  = 2'b00;
  localparam logic [1:0] SEL_MEM = 2'b10;
  localparam logic [1:0] SEL_WB  = 2'b11;

  logic              ex_wr, ex_load;
  logic [AW-1:0]     ex_dst;
  logic              mem_wr, mem_load;
  logic [AW-1:0]     mem_dst;
  logic              wb_wr_q, wb_load;
  logic [AW-1:0]     wb_dst_q;
  logic [2*NSRC-1:0] fwd_sel_q;
  logic [CNT_W-1:0]  stall_cnt_q;

  logic              ex_prod, mem_prod;
  logic [NSRC-1:0]   hazard;
  logic [2*NSRC-1:0] sel_next;
  logic              bubble;

  // Register 0 is hardwired, so writes to it never produce a forwardable value.
  assign ex_prod  = ex_wr  && (ex_dst  != '0);
  assign mem_prod = mem_wr && (mem_dst != '0);

  always_comb begin
    hazard   = '0;
    sel_next = '0;
    for (int i = 0; i < NSRC; i++) begin
      logic [AW-1:0] src;
      src = id_src[i*AW +: AW];
      hazard[i] = id_valid && id_src_used[i] && !flush &&
                  ex_prod && ex_load && (ex_dst == src);
      // The EX producer is one cycle younger than the MEM one, so it wins.
      // A load in EX has no result yet; that case is covered by the stall.
      if (!id_src_used[i]) begin
        sel_next[2*i +: 2] = SEL_RF;
      end else if (ex_prod && !ex_load && (ex_dst == src)) begin
        sel_next[2*i +: 2] = SEL_MEM;
      end else if (mem_prod && (mem_dst == src)) begin
        sel_next[2*i +: 2] = SEL_WB;
      end else begin
        sel_next[2*i +: 2] = SEL_RF;
      end
    end
  end

  assign stall  = |hazard;
  assign bubble = flush || stall || !id_valid;

  always_ff @(posedge clk) begin
    if (reset) begin
      ex_wr       <= 1'b0;
      ex_load     <= 1'b0;
      ex_dst      <= '0;
      mem_wr      <= 1'b0;
      mem_load    <= 1'b0;
      mem_dst     <= '0;
      wb_wr_q     <= 1'b0;
      wb_load     <= 1'b0;
      wb_dst_q    <= '0;
      fwd_sel_q   <= '0;
      stall_cnt_q <= '0;
    end else if (!stall_ext) begin
      wb_wr_q  <= mem_wr;
      wb_load  <= mem_load;
      wb_dst_q <= mem_dst;
      mem_wr   <= ex_wr;
      mem_load <= ex_load;
      mem_dst  <= ex_dst;
      if (bubble) begin
        ex_wr     <= 1'b0;
        ex_load   <= 1'b0;
        ex_dst    <= '0;
        fwd_sel_q <= '0;
      end else begin
        ex_wr     <= id_wr;
        ex_load   <= id_load;
        ex_dst    <= id_dst;
        fwd_sel_q <= sel_next;
      end
      if (stall && (stall_cnt_q != '1)) begin
        stall_cnt_q <= stall_cnt_q + 1'b1;
      end
    end
  end

  // The load flag only matters while in EX; WB keeps it for a uniform tag.
  logic unused_wb_load;
  assign unused_wb_load = wb_load;

  assign fwd_sel   = fwd_sel_q;
  assign wb_dst    = wb_dst_q;
  assign wb_wr     = wb_wr_q;
  assign stall_cnt = stall_cnt_q;

endmodule

// File: tb/tb_fwd_hazard_unit.sv
// tb/tb_fwd_hazard_unit.sv - scoreboard bench for fwd_hazard_unit
module tb_fwd_hazard_unit;

  logic        clk = 1'b0;
  logic        reset, stall_ext, flush, id_valid, id_wr, id_load;
  logic [9:0]  id_src;
  logic [1:0]  id_src_used;
  logic [4:0]  id_dst;
  logic        stall, wb_wr;
  logic [3:0]  fwd_sel;
  logic [4:0]  wb_dst;
  logic [15:0] stall_cnt;
  logic        stall_s, wb_wr_s;
  logic [3:0]  fwd_sel_s;
  logic [4:0]  wb_dst_s;
  logic [1:0]  stall_cnt_s;

  always #5 clk = ~clk;

  fwd_hazard_unit #(.AW(5), .NSRC(2), .CNT_W(16)) dut (
    .clk(clk), .reset(reset), .stall_ext(stall_ext), .flush(flush),
    .id_valid(id_valid), .id_src(id_src), .id_src_used(id_src_used),
    .id_dst(id_dst), .id_wr(id_wr), .id_load(id_load),
    .stall(stall), .fwd_sel(fwd_sel), .wb_dst(wb_dst), .wb_wr(wb_wr),
    .stall_cnt(stall_cnt)
  );

  fwd_hazard_unit #(.AW(5), .NSRC(2), .CNT_W(2)) dut_sat (
    .clk(clk), .reset(reset), .stall_ext(stall_ext), .flush(flush),
    .id_valid(id_valid), .id_src(id_src), .id_src_used(id_src_used),
    .id_dst(id_dst), .id_wr(id_wr), .id_load(id_load),
    .stall(stall_s), .fwd_sel(fwd_sel_s), .wb_dst(wb_dst_s), .wb_wr(wb_wr_s),
    .stall_cnt(stall_cnt_s)
  );

  int n_checks = 0;
  int n_pass   = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
  endtask

  typedef struct packed {
    logic       wr;
    logic       ld;
    logic [4:0] dst;
  } tag_t;

  typedef struct packed {
    logic [3:0]  sel;
    logic [4:0]  wb_dst;
    logic        wb_wr;
    logic [15:0] cnt;
    logic [1:0]  cnt2;
  } exp_t;

  // Reference model: pipe[0]=EX, pipe[1]=MEM, pipe[2]=WB
  tag_t        pipe [3];
  logic [3:0]  m_sel;
  logic [15:0] m_cnt;
  logic [1:0]  m_cnt2;
  exp_t        sb [$];

  task automatic model_clear();
    for (int k = 0; k < 3; k++) pipe[k] = '0;
    m_sel = '0; m_cnt = '0; m_cnt2 = '0;
  endtask

  task automatic push_exp();
    exp_t e;
    e.sel = m_sel; e.wb_dst = pipe[2].dst; e.wb_wr = pipe[2].wr;
    e.cnt = m_cnt; e.cnt2 = m_cnt2;
    sb.push_back(e);
  endtask

  task automatic pop_cmp();
    exp_t e;
    if (sb.size() == 0) begin
      check("sb_empty", 1, 0);
      return;
    end
    e = sb.pop_front();
    check("fwd_sel", fwd_sel, e.sel);
    check("wb_dst", wb_dst, e.wb_dst);
    check("wb_wr", wb_wr, e.wb_wr);
    check("stall_cnt", stall_cnt, e.cnt);
    check("stall_cnt_sat", stall_cnt_s, e.cnt2);
  endtask

  // One cycle: drive ID, check the combinational stall, predict and compare the edge.
  task automatic step(input logic v, input logic [4:0] s0, input logic [4:0] s1,
                      input logic [1:0] used, input logic [4:0] d, input logic wr,
                      input logic ld, input logic fl, input logic se, input logic rs);
    logic       m_stall;
    logic [3:0] nsel;
    logic [4:0] src;
    logic       p_ex, p_mem;
    id_valid = v; id_src = {s1, s0}; id_src_used = used; id_dst = d;
    id_wr = wr; id_load = ld; flush = fl; stall_ext = se; reset = rs;
    @(negedge clk);
    m_stall = 1'b0;
    nsel = '0;
    p_ex  = pipe[0].wr && pipe[0].dst != 0;
    p_mem = pipe[1].wr && pipe[1].dst != 0;
    for (int i = 0; i < 2; i++) begin
      src = (i == 0) ? s0 : s1;
      if (v && used[i] && !fl && p_ex && pipe[0].ld && pipe[0].dst == src) m_stall = 1'b1;
      if (used[i]) begin
        if (p_ex && !pipe[0].ld && pipe[0].dst == src) nsel[2*i +: 2] = 2'b10;
        else if (p_mem && pipe[1].dst == src)          nsel[2*i +: 2] = 2'b11;
      end
    end
    check("stall", stall, m_stall);
    check("stall_sat", stall_s, m_stall);
    if (rs) begin
      model_clear();
    end else if (!se) begin
      pipe[2] = pipe[1];
      pipe[1] = pipe[0];
      if (fl || m_stall || !v) begin
        pipe[0] = '0; m_sel = '0;
      end else begin
        pipe[0] = '{wr, ld, d}; m_sel = nsel;
      end
      if (m_stall) begin
        if (m_cnt != 16'hffff) m_cnt++;
        if (m_cnt2 != 2'b11) m_cnt2++;
      end
    end
    push_exp();
    @(posedge clk);
    #1;
    pop_cmp();
  endtask

  task automatic nop();
    step(0, 0, 0, 2'b00, 0, 0, 0, 0, 0, 0);
  endtask

  initial begin
    reset = 1; stall_ext = 0; flush = 0; id_valid = 0; id_src = '0;
    id_src_used = '0; id_dst = '0; id_wr = 0; id_load = 0;
    model_clear();
    @(posedge clk); @(posedge clk); #1;
    push_exp();
    pop_cmp();
    check("reset_stall", stall, 0);

    // ALU back-to-back
    step(1, 1, 2, 2'b11, 3, 1, 0, 0, 0, 0);
    step(1, 3, 7, 2'b11, 9, 1, 0, 0, 0, 0);
    check("alu_fwd", fwd_sel, 4'b0010);
    repeat (3) nop();

    // distance 2 with priority, then MEM-only
    step(1, 0, 0, 2'b00, 4, 1, 0, 0, 0, 0);
    step(1, 0, 0, 2'b00, 4, 1, 0, 0, 0, 0);
    step(1, 4, 4, 2'b11, 0, 0, 0, 0, 0, 0);
    check("prio_fwd", fwd_sel, 4'b1010);
    repeat (3) nop();
    step(1, 0, 0, 2'b00, 4, 1, 0, 0, 0, 0);
    nop();
    step(1, 4, 4, 2'b11, 0, 0, 0, 0, 0, 0);
    check("dist2_fwd", fwd_sel, 4'b1111);
    repeat (3) nop();

    // load-use
    step(1, 0, 0, 2'b00, 5, 1, 1, 0, 0, 0);
    step(1, 1, 5, 2'b11, 6, 1, 0, 0, 0, 0);
    check("lu_cnt", stall_cnt, 1);
    check("lu_bubble", fwd_sel, 4'b0000);
    step(1, 1, 5, 2'b11, 6, 1, 0, 0, 0, 0);
    check("lu_fwd", fwd_sel, 4'b1100);
    repeat (3) nop();

    // zero register and unused operand
    step(1, 0, 0, 2'b00, 0, 1, 1, 0, 0, 0);
    step(1, 0, 0, 2'b11, 2, 1, 0, 0, 0, 0);
    check("r0_fwd", fwd_sel, 4'b0000);
    step(1, 0, 0, 2'b00, 6, 1, 0, 0, 0, 0);
    step(1, 6, 1, 2'b00, 2, 1, 0, 0, 0, 0);
    check("unused_fwd", fwd_sel, 4'b0000);
    repeat (3) nop();

    // freeze during pending load-use
    step(1, 0, 0, 2'b00, 7, 1, 1, 0, 0, 0);
    repeat (3) step(1, 7, 0, 2'b01, 2, 1, 0, 0, 1, 0);
    check("frz_cnt", stall_cnt, 1);
    step(1, 7, 0, 2'b01, 2, 1, 0, 0, 0, 0);
    check("frz_rel_cnt", stall_cnt, 2);
    step(1, 7, 0, 2'b01, 2, 1, 0, 0, 0, 0);
    check("frz_fwd", fwd_sel, 4'b0011);
    repeat (3) nop();

    // flush of a hazardous writer
    step(1, 0, 0, 2'b00, 8, 1, 1, 0, 0, 0);
    step(1, 8, 0, 2'b01, 9, 1, 0, 1, 0, 0);
    nop();
    nop();
    check("flush_wb_wr", wb_wr, 0);
    nop();

    // saturation: five more load-use stalls
    for (int k = 0; k < 5; k++) begin
      step(1, 0, 0, 2'b00, 10, 1, 1, 0, 0, 0);
      step(1, 10, 0, 2'b01, 2, 1, 0, 0, 0, 0);
      step(1, 10, 0, 2'b01, 2, 1, 0, 0, 0, 0);
    end
    check("sat_cnt", stall_cnt_s, 2'b11);
    repeat (3) nop();

    // randomized traffic over a small register set
    for (int k = 0; k < 150; k++) begin
      step($urandom_range(0, 9) != 0, 5'($urandom_range(0, 3)), 5'($urandom_range(0, 3)),
           2'($urandom_range(0, 3)), 5'($urandom_range(0, 3)), 1'($urandom_range(0, 1)),
           1'($urandom_range(0, 1)), $urandom_range(0, 7) == 0,
           $urandom_range(0, 7) == 0, 1'b0);
    end
    repeat (3) nop();

    // reset during a stall
    step(1, 0, 0, 2'b00, 11, 1, 1, 0, 0, 0);
    step(1, 11, 0, 2'b01, 2, 1, 0, 0, 0, 1);
    check("rst_fwd", fwd_sel, 0);
    check("rst_cnt", stall_cnt, 0);
    check("rst_wb", {wb_wr, wb_dst}, 0);
    reset = 0;
    #1;
    check("rst_stall", stall, 0);
    step(1, 11, 0, 2'b01, 2, 1, 0, 0, 0, 0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
